// File: rtl/rv64i_pipeline_core.sv
// rtl/rv64i_pipeline_core.sv - five-stage in-order RV64I integer core
// IF/ID/EX/MEM/WB with full forwarding, load-use stall and EX-resolved redirects.
module rv64i_pipeline_core #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] im_addr_mem0,
    input  logic [31:0] im_dout_mem0,
    output logic [2:0]  dm_rd_ctrl_mem,
    output logic [2:0]  dm_wr_ctrl_mem,
    output logic [63:0] dm_addr_mem,
    output logic [63:0] dm_din_mem,
    input  logic [63:0] dm_dout_mem
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // ALU op = {variant bit (instr[30]), funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    logic [63:0] r_regs [0:31];

    logic [63:0] r_pc;

    logic        r_ifid_valid;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;

    logic        r_idex_valid;
    logic [63:0] r_idex_pc;
    logic [63:0] r_idex_imm;
    logic [63:0] r_idex_rs1_val;
    logic [63:0] r_idex_rs2_val;
    logic [4:0]  r_idex_rs1;
    logic [4:0]  r_idex_rs2;
    logic [4:0]  r_idex_rd;
    logic [2:0]  r_idex_funct3;
    logic [3:0]  r_idex_alu_op;
    logic        r_idex_is_w;
    logic [1:0]  r_idex_src_a;
    logic        r_idex_src_b_imm;
    logic        r_idex_reg_write;
    logic        r_idex_link;
    logic        r_idex_branch;
    logic        r_idex_jal;
    logic        r_idex_jalr;
    logic [2:0]  r_idex_rd_ctrl;
    logic [2:0]  r_idex_wr_ctrl;

    logic        r_exmem_valid;
    logic        r_exmem_reg_write;
    logic [4:0]  r_exmem_rd;
    logic [63:0] r_exmem_result;
    logic [63:0] r_exmem_store_data;
    logic [2:0]  r_exmem_rd_ctrl;
    logic [2:0]  r_exmem_wr_ctrl;

    logic        r_memwb_valid;
    logic        r_memwb_reg_write;
    logic [4:0]  r_memwb_rd;
    logic [63:0] r_memwb_wdata;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [63:0] w_imm_i;
    logic [63:0] w_imm_s;
    logic [63:0] w_imm_b;
    logic [63:0] w_imm_u;
    logic [63:0] w_imm_j;

    logic [63:0] w_dec_imm;
    logic [3:0]  w_dec_alu_op;
    logic        w_dec_is_w;
    logic [1:0]  w_dec_src_a;
    logic        w_dec_src_b_imm;
    logic        w_dec_reg_write;
    logic        w_dec_link;
    logic        w_dec_branch;
    logic        w_dec_jal;
    logic        w_dec_jalr;
    logic [2:0]  w_dec_rd_ctrl;
    logic [2:0]  w_dec_wr_ctrl;

    logic        w_rf_wen;
    logic [63:0] w_rs1_val;
    logic [63:0] w_rs2_val;
    logic        w_load_use;

    logic [63:0] w_fwd_a;
    logic [63:0] w_fwd_b;
    logic [63:0] w_op_a;
    logic [63:0] w_op_b;
    logic [5:0]  w_shamt;
    logic [63:0] w_a_sext32;
    logic [63:0] w_sra64;
    logic [63:0] w_sra32;
    logic [63:0] w_alu_raw;
    logic [63:0] w_alu_res;
    logic [63:0] w_ex_result;
    logic        w_br_cond;
    logic        w_take;
    logic [63:0] w_target;
    logic [63:0] w_mem_wdata;

    assign w_instr  = r_ifid_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_imm_i  = {{52{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{52{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{52{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {{32{w_instr[31]}}, w_instr[31:12], 12'b0};
    assign w_imm_j  = {{44{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    always_comb begin
        w_dec_imm       = 64'd0;
        w_dec_alu_op    = ALU_ADD;
        w_dec_is_w      = 1'b0;
        w_dec_src_a     = SRC_A_RS1;
        w_dec_src_b_imm = 1'b0;
        w_dec_reg_write = 1'b0;
        w_dec_link      = 1'b0;
        w_dec_branch    = 1'b0;
        w_dec_jal       = 1'b0;
        w_dec_jalr      = 1'b0;
        w_dec_rd_ctrl   = 3'd0;
        w_dec_wr_ctrl   = 3'd0;
        case (w_opcode)
            OP_LUI: begin
                w_dec_imm = w_imm_u; w_dec_src_a = SRC_A_ZERO;
                w_dec_src_b_imm = 1'b1; w_dec_reg_write = 1'b1;
            end
            OP_AUIPC: begin
                w_dec_imm = w_imm_u; w_dec_src_a = SRC_A_PC;
                w_dec_src_b_imm = 1'b1; w_dec_reg_write = 1'b1;
            end
            OP_JAL: begin
                w_dec_imm = w_imm_j; w_dec_jal = 1'b1;
                w_dec_reg_write = 1'b1; w_dec_link = 1'b1;
            end
            OP_JALR: begin
                w_dec_imm = w_imm_i; w_dec_jalr = 1'b1;
                w_dec_reg_write = 1'b1; w_dec_link = 1'b1;
            end
            OP_BRANCH: begin
                w_dec_imm    = w_imm_b;
                w_dec_branch = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            OP_LOAD: begin
                w_dec_imm = w_imm_i; w_dec_src_b_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_dec_rd_ctrl = 3'd1;
                    3'b100:  w_dec_rd_ctrl = 3'd2;
                    3'b001:  w_dec_rd_ctrl = 3'd3;
                    3'b101:  w_dec_rd_ctrl = 3'd4;
                    3'b010:  w_dec_rd_ctrl = 3'd5;
                    3'b110:  w_dec_rd_ctrl = 3'd6;
                    3'b011:  w_dec_rd_ctrl = 3'd7;
                    default: w_dec_rd_ctrl = 3'd0;
                endcase
                w_dec_reg_write = (w_dec_rd_ctrl != 3'd0);
            end
            OP_STORE: begin
                w_dec_imm = w_imm_s; w_dec_src_b_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_dec_wr_ctrl = 3'd1;
                    3'b001:  w_dec_wr_ctrl = 3'd2;
                    3'b010:  w_dec_wr_ctrl = 3'd3;
                    3'b011:  w_dec_wr_ctrl = 3'd4;
                    default: w_dec_wr_ctrl = 3'd0;
                endcase
            end
            OP_IMM: begin
                w_dec_imm = w_imm_i; w_dec_src_b_imm = 1'b1; w_dec_reg_write = 1'b1;
                w_dec_alu_op = {(w_f3 == 3'b101) & w_instr[30], w_f3};
            end
            OP_REG: begin
                w_dec_reg_write = 1'b1;
                w_dec_alu_op = {((w_f3 == 3'b000) | (w_f3 == 3'b101)) & w_instr[30], w_f3};
            end
            OP_IMM32: begin
                w_dec_imm = w_imm_i; w_dec_src_b_imm = 1'b1; w_dec_is_w = 1'b1;
                w_dec_reg_write = (w_f3 == 3'b000) | (w_f3 == 3'b001) | (w_f3 == 3'b101);
                w_dec_alu_op = {(w_f3 == 3'b101) & w_instr[30], w_f3};
            end
            OP_REG32: begin
                w_dec_is_w = 1'b1;
                w_dec_reg_write = (w_f3 == 3'b000) | (w_f3 == 3'b001) | (w_f3 == 3'b101);
                w_dec_alu_op = {((w_f3 == 3'b000) | (w_f3 == 3'b101)) & w_instr[30], w_f3};
            end
            default: ;
        endcase
    end

    // Same-cycle WB write is visible to the ID read.
    assign w_rf_wen  = r_memwb_valid & r_memwb_reg_write & (r_memwb_rd != 5'd0);
    assign w_rs1_val = (w_rs1 == 5'd0) ? 64'd0 :
                       (w_rf_wen && (r_memwb_rd == w_rs1)) ? r_memwb_wdata : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 64'd0 :
                       (w_rf_wen && (r_memwb_rd == w_rs2)) ? r_memwb_wdata : r_regs[w_rs2];

    assign w_load_use = r_idex_valid & (r_idex_rd_ctrl != 3'd0) & (r_idex_rd != 5'd0) &
                        r_ifid_valid & ((r_idex_rd == w_rs1) | (r_idex_rd == w_rs2));

    assign w_fwd_a = (r_exmem_valid && r_exmem_reg_write && (r_exmem_rd != 5'd0) &&
                      (r_exmem_rd == r_idex_rs1)) ? r_exmem_result :
                     (w_rf_wen && (r_memwb_rd == r_idex_rs1)) ? r_memwb_wdata : r_idex_rs1_val;
    assign w_fwd_b = (r_exmem_valid && r_exmem_reg_write && (r_exmem_rd != 5'd0) &&
                      (r_exmem_rd == r_idex_rs2)) ? r_exmem_result :
                     (w_rf_wen && (r_memwb_rd == r_idex_rs2)) ? r_memwb_wdata : r_idex_rs2_val;

    assign w_op_a = (r_idex_src_a == SRC_A_PC)   ? r_idex_pc :
                    (r_idex_src_a == SRC_A_ZERO) ? 64'd0 : w_fwd_a;
    assign w_op_b = r_idex_src_b_imm ? r_idex_imm : w_fwd_b;
    assign w_shamt = r_idex_is_w ? {1'b0, w_op_b[4:0]} : w_op_b[5:0];
    assign w_a_sext32 = {{32{w_op_a[31]}}, w_op_a[31:0]};
    assign w_sra64 = $signed(w_op_a) >>> w_shamt;
    assign w_sra32 = $signed(w_a_sext32) >>> w_shamt;

    always_comb begin
        w_alu_raw = 64'd0;
        case (r_idex_alu_op)
            ALU_ADD:  w_alu_raw = w_op_a + w_op_b;
            ALU_SUB:  w_alu_raw = w_op_a - w_op_b;
            ALU_SLL:  w_alu_raw = w_op_a << w_shamt;
            ALU_SLT:  w_alu_raw = {63'd0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU: w_alu_raw = {63'd0, w_op_a < w_op_b};
            ALU_XOR:  w_alu_raw = w_op_a ^ w_op_b;
            ALU_SRL:  w_alu_raw = r_idex_is_w ? ({32'd0, w_op_a[31:0]} >> w_shamt)
                                              : (w_op_a >> w_shamt);
            ALU_SRA:  w_alu_raw = r_idex_is_w ? w_sra32 : w_sra64;
            ALU_OR:   w_alu_raw = w_op_a | w_op_b;
            ALU_AND:  w_alu_raw = w_op_a & w_op_b;
            default:  w_alu_raw = 64'd0;
        endcase
    end

    assign w_alu_res   = r_idex_is_w ? {{32{w_alu_raw[31]}}, w_alu_raw[31:0]} : w_alu_raw;
    assign w_ex_result = r_idex_link ? (r_idex_pc + 64'd4) : w_alu_res;

    always_comb begin
        case (r_idex_funct3)
            3'b000:  w_br_cond = (w_fwd_a == w_fwd_b);
            3'b001:  w_br_cond = (w_fwd_a != w_fwd_b);
            3'b100:  w_br_cond = ($signed(w_fwd_a) < $signed(w_fwd_b));
            3'b101:  w_br_cond = !($signed(w_fwd_a) < $signed(w_fwd_b));
            3'b110:  w_br_cond = (w_fwd_a < w_fwd_b);
            3'b111:  w_br_cond = !(w_fwd_a < w_fwd_b);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_take   = r_idex_valid & (r_idex_jal | r_idex_jalr | (r_idex_branch & w_br_cond));
    assign w_target = r_idex_jalr ? ((w_fwd_a + r_idex_imm) & ~64'd1) : (r_idex_pc + r_idex_imm);

    assign w_mem_wdata = (r_exmem_rd_ctrl != 3'd0) ? dm_dout_mem : r_exmem_result;

    assign im_addr_mem0   = r_pc;
    assign dm_rd_ctrl_mem = r_exmem_rd_ctrl;
    assign dm_wr_ctrl_mem = r_exmem_wr_ctrl;
    assign dm_addr_mem    = r_exmem_result;
    assign dm_din_mem     = r_exmem_store_data;

    // A redirect overrides a concurrent load-use stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 64'd0;
            r_ifid_instr <= 32'd0;
        end else if (w_take) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
        end else if (!w_load_use) begin
            r_pc         <= r_pc + 64'd4;
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= im_dout_mem0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idex_valid     <= 1'b0;
            r_idex_pc        <= 64'd0;
            r_idex_imm       <= 64'd0;
            r_idex_rs1_val   <= 64'd0;
            r_idex_rs2_val   <= 64'd0;
            r_idex_rs1       <= 5'd0;
            r_idex_rs2       <= 5'd0;
            r_idex_rd        <= 5'd0;
            r_idex_funct3    <= 3'd0;
            r_idex_alu_op    <= ALU_ADD;
            r_idex_is_w      <= 1'b0;
            r_idex_src_a     <= SRC_A_RS1;
            r_idex_src_b_imm <= 1'b0;
            r_idex_reg_write <= 1'b0;
            r_idex_link      <= 1'b0;
            r_idex_branch    <= 1'b0;
            r_idex_jal       <= 1'b0;
            r_idex_jalr      <= 1'b0;
            r_idex_rd_ctrl   <= 3'd0;
            r_idex_wr_ctrl   <= 3'd0;
        end else begin
            r_idex_valid     <= r_ifid_valid & !w_take & !w_load_use;
            r_idex_pc        <= r_ifid_pc;
            r_idex_imm       <= w_dec_imm;
            r_idex_rs1_val   <= w_rs1_val;
            r_idex_rs2_val   <= w_rs2_val;
            r_idex_rs1       <= w_rs1;
            r_idex_rs2       <= w_rs2;
            r_idex_rd        <= w_rd;
            r_idex_funct3    <= w_f3;
            r_idex_alu_op    <= w_dec_alu_op;
            r_idex_is_w      <= w_dec_is_w;
            r_idex_src_a     <= w_dec_src_a;
            r_idex_src_b_imm <= w_dec_src_b_imm;
            r_idex_reg_write <= w_dec_reg_write;
            r_idex_link      <= w_dec_link;
            r_idex_branch    <= w_dec_branch;
            r_idex_jal       <= w_dec_jal;
            r_idex_jalr      <= w_dec_jalr;
            r_idex_rd_ctrl   <= w_dec_rd_ctrl;
            r_idex_wr_ctrl   <= w_dec_wr_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exmem_valid      <= 1'b0;
            r_exmem_reg_write  <= 1'b0;
            r_exmem_rd         <= 5'd0;
            r_exmem_result     <= 64'd0;
            r_exmem_store_data <= 64'd0;
            r_exmem_rd_ctrl    <= 3'd0;
            r_exmem_wr_ctrl    <= 3'd0;
            r_memwb_valid      <= 1'b0;
            r_memwb_reg_write  <= 1'b0;
            r_memwb_rd         <= 5'd0;
            r_memwb_wdata      <= 64'd0;
        end else begin
            r_exmem_valid      <= r_idex_valid;
            r_exmem_reg_write  <= r_idex_reg_write;
            r_exmem_rd         <= r_idex_rd;
            r_exmem_result     <= w_ex_result;
            r_exmem_store_data <= w_fwd_b;
            r_exmem_rd_ctrl    <= r_idex_valid ? r_idex_rd_ctrl : 3'd0;
            r_exmem_wr_ctrl    <= r_idex_valid ? r_idex_wr_ctrl : 3'd0;
            r_memwb_valid      <= r_exmem_valid;
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_rd         <= r_exmem_rd;
            r_memwb_wdata      <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rf_wen) begin
            r_regs[r_memwb_rd] <= r_memwb_wdata;
        end
    end

endmodule

// File: tb/tb_rv64i_pipeline_core.sv
// tb/tb_rv64i_pipeline_core.sv - directed program bench for rv64i_pipeline_core
module tb_rv64i_pipeline_core;

    logic        clk;
    logic        rst;
    logic [63:0] im_addr_mem0;
    logic [31:0] im_dout_mem0;
    logic [2:0]  dm_rd_ctrl_mem;
    logic [2:0]  dm_wr_ctrl_mem;
    logic [63:0] dm_addr_mem;
    logic [63:0] dm_din_mem;
    logic [63:0] dm_dout_mem;

    rv64i_pipeline_core #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr_mem0   (im_addr_mem0),
        .im_dout_mem0   (im_dout_mem0),
        .dm_rd_ctrl_mem (dm_rd_ctrl_mem),
        .dm_wr_ctrl_mem (dm_wr_ctrl_mem),
        .dm_addr_mem    (dm_addr_mem),
        .dm_din_mem     (dm_din_mem),
        .dm_dout_mem    (dm_dout_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] imem [0:255];
    logic [7:0]  dmem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    assign im_dout_mem0 = imem[im_addr_mem0[9:2]];

    always_comb begin
        logic [63:0] raw;
        logic [7:0]  a;
        a   = dm_addr_mem[7:0];
        raw = 64'd0;
        for (int k = 0; k < 8; k++) raw[8*k +: 8] = dmem[a + 8'(k)];
        case (dm_rd_ctrl_mem)
            3'd1:    dm_dout_mem = {{56{raw[7]}}, raw[7:0]};
            3'd2:    dm_dout_mem = {56'd0, raw[7:0]};
            3'd3:    dm_dout_mem = {{48{raw[15]}}, raw[15:0]};
            3'd4:    dm_dout_mem = {48'd0, raw[15:0]};
            3'd5:    dm_dout_mem = {{32{raw[31]}}, raw[31:0]};
            3'd6:    dm_dout_mem = {32'd0, raw[31:0]};
            3'd7:    dm_dout_mem = raw;
            default: dm_dout_mem = 64'd0;
        endcase
    end

    // Data memory is preloaded while reset is held, then takes stores.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 256; k++) dmem[k] <= 8'h00;
            dmem[8'h83] <= 8'h80;
            for (int k = 0; k < 8; k++) dmem[8'h88 + k] <= 8'h88 - 8'(k * 8'h11);
        end else begin
            int n;
            case (dm_wr_ctrl_mem)
                3'd1:    n = 1;
                3'd2:    n = 2;
                3'd3:    n = 4;
                3'd4:    n = 8;
                default: n = 0;
            endcase
            for (int k = 0; k < n; k++) dmem[dm_addr_mem[7:0] + 8'(k)] <= dm_din_mem[8*k +: 8];
        end
    end

    logic [63:0] trace [0:199];
    int          visits [0:63];
    int          n_lw;
    int          n_st;
    logic [63:0] st_addr [0:31];
    logic [63:0] st_data [0:31];
    logic [2:0]  st_ctrl [0:31];

    task automatic sample(input int k);
        trace[k] = im_addr_mem0;
        if (im_addr_mem0 < 64'h100) visits[im_addr_mem0[7:2]]++;
        if (dm_rd_ctrl_mem == 3'd5) n_lw++;
        if (dm_wr_ctrl_mem != 3'd0 && n_st < 32) begin
            st_addr[n_st] = dm_addr_mem;
            st_data[n_st] = dm_din_mem;
            st_ctrl[n_st] = dm_wr_ctrl_mem;
            n_st++;
        end
    endtask

    logic [63:0] exp_addr [0:15];
    logic [63:0] exp_data [0:15];
    logic [2:0]  exp_ctrl [0:15];

    initial begin
        for (int k = 0; k < 256; k++) imem[k] = s_type(12'hF8, 5'd0, 5'd0, 3'b011);
        imem[8'h00>>2] = i_type(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        imem[8'h04>>2] = i_type(12'd3, 5'd1, 3'b000, 5'd2, 7'b0010011);
        imem[8'h08>>2] = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
        imem[8'h0C>>2] = s_type(12'h40, 5'd3, 5'd0, 3'b011);
        imem[8'h10>>2] = b_type(13'd12, 5'd0, 5'd0, 3'b000);
        imem[8'h14>>2] = i_type(12'd99, 5'd0, 3'b000, 5'd3, 7'b0010011);
        imem[8'h18>>2] = s_type(12'h48, 5'd3, 5'd0, 3'b011);
        imem[8'h1C>>2] = i_type(12'd0, 5'd3, 3'b000, 5'd11, 7'b0010011);
        imem[8'h20>>2] = j_type(21'd8, 5'd1);
        imem[8'h24>>2] = j_type(21'h3C, 5'd0);
        imem[8'h28>>2] = s_type(12'h50, 5'd1, 5'd0, 3'b011);
        imem[8'h2C>>2] = i_type(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);
        imem[8'h60>>2] = i_type(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011);
        imem[8'h64>>2] = s_type(12'h58, 5'd0, 5'd0, 3'b011);
        imem[8'h68>>2] = s_type(12'h60, 5'd11, 5'd0, 3'b011);
        imem[8'h6C>>2] = i_type(12'h80, 5'd0, 3'b000, 5'd5, 7'b0010011);
        imem[8'h70>>2] = i_type(12'd0, 5'd5, 3'b010, 5'd4, 7'b0000011);
        imem[8'h74>>2] = r_type(7'h00, 5'd4, 5'd4, 3'b000, 5'd6, 7'b0110011);
        imem[8'h78>>2] = s_type(12'h68, 5'd6, 5'd0, 3'b011);
        imem[8'h7C>>2] = i_type(12'd8, 5'd5, 3'b011, 5'd7, 7'b0000011);
        imem[8'h80>>2] = s_type(12'h08, 5'd7, 5'd0, 3'b011);
        imem[8'h84>>2] = i_type(12'd8, 5'd0, 3'b100, 5'd8, 7'b0000011);
        imem[8'h88>>2] = s_type(12'h70, 5'd8, 5'd0, 3'b011);
        imem[8'h8C>>2] = i_type(12'd1, 5'd0, 3'b000, 5'd13, 7'b0010011);
        imem[8'h90>>2] = i_type(12'd31, 5'd13, 3'b001, 5'd13, 7'b0010011);
        imem[8'h94>>2] = r_type(7'h00, 5'd0, 5'd13, 3'b000, 5'd14, 7'b0111011);
        imem[8'h98>>2] = i_type(12'h404, 5'd14, 3'b101, 5'd15, 7'b0010011);
        imem[8'h9C>>2] = i_type(12'd4, 5'd14, 3'b101, 5'd16, 7'b0011011);
        imem[8'hA0>>2] = s_type(12'h78, 5'd14, 5'd0, 3'b011);
        imem[8'hA4>>2] = s_type(12'h90, 5'd15, 5'd0, 3'b011);
        imem[8'hA8>>2] = s_type(12'h98, 5'd16, 5'd0, 3'b011);
        imem[8'hAC>>2] = r_type(7'h00, 5'd14, 5'd0, 3'b011, 5'd17, 7'b0110011);
        imem[8'hB0>>2] = r_type(7'h20, 5'd1, 5'd0, 3'b000, 5'd18, 7'b0110011);
        imem[8'hB4>>2] = s_type(12'hA0, 5'd17, 5'd0, 3'b011);
        imem[8'hB8>>2] = s_type(12'hA8, 5'd18, 5'd0, 3'b011);
        imem[8'hBC>>2] = b_type(13'd8, 5'd0, 5'd0, 3'b001);
        imem[8'hC0>>2] = i_type(12'd3, 5'd0, 3'b000, 5'd19, 7'b0010011);
        imem[8'hC4>>2] = b_type(13'd8, 5'd0, 5'd14, 3'b100);
        imem[8'hC8>>2] = i_type(12'd55, 5'd0, 3'b000, 5'd19, 7'b0010011);
        imem[8'hCC>>2] = s_type(12'hB0, 5'd19, 5'd0, 3'b011);
        imem[8'hD0>>2] = {20'hFFFFF, 5'd20, 7'b0110111};
        imem[8'hD4>>2] = {20'h00001, 5'd21, 7'b0010111};
        imem[8'hD8>>2] = s_type(12'hB8, 5'd20, 5'd0, 3'b011);
        imem[8'hDC>>2] = s_type(12'hC0, 5'd21, 5'd0, 3'b011);
        imem[8'hE0>>2] = s_type(12'hC8, 5'd1, 5'd0, 3'b000);
        imem[8'hE4>>2] = j_type(21'd0, 5'd0);

        exp_addr[0]  = 64'h40; exp_data[0]  = 64'd13;
        exp_addr[1]  = 64'h50; exp_data[1]  = 64'h24;
        exp_addr[2]  = 64'h58; exp_data[2]  = 64'd0;
        exp_addr[3]  = 64'h60; exp_data[3]  = 64'd13;
        exp_addr[4]  = 64'h68; exp_data[4]  = 64'hFFFF_FFFF_0000_0000;
        exp_addr[5]  = 64'h08; exp_data[5]  = 64'h1122_3344_5566_7788;
        exp_addr[6]  = 64'h70; exp_data[6]  = 64'h88;
        exp_addr[7]  = 64'h78; exp_data[7]  = 64'hFFFF_FFFF_8000_0000;
        exp_addr[8]  = 64'h90; exp_data[8]  = 64'hFFFF_FFFF_F800_0000;
        exp_addr[9]  = 64'h98; exp_data[9]  = 64'h0000_0000_0800_0000;
        exp_addr[10] = 64'hA0; exp_data[10] = 64'd1;
        exp_addr[11] = 64'hA8; exp_data[11] = 64'hFFFF_FFFF_FFFF_FFDC;
        exp_addr[12] = 64'hB0; exp_data[12] = 64'd3;
        exp_addr[13] = 64'hB8; exp_data[13] = 64'hFFFF_FFFF_FFFF_F000;
        exp_addr[14] = 64'hC0; exp_data[14] = 64'h10D4;
        exp_addr[15] = 64'hC8; exp_data[15] = 64'h24;
        for (int k = 0; k < 16; k++) exp_ctrl[k] = (k == 15) ? 3'd1 : 3'd4;

        for (int k = 0; k < 64; k++) visits[k] = 0;
        n_lw = 0;
        n_st = 0;

        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_im_addr", im_addr_mem0, 64'h0);
        check_eq("rst_rd_ctrl", {61'd0, dm_rd_ctrl_mem}, 64'd0);
        check_eq("rst_wr_ctrl", {61'd0, dm_wr_ctrl_mem}, 64'd0);
        check_eq("rst_dm_addr", dm_addr_mem, 64'h0);
        check_eq("rst_dm_din", dm_din_mem, 64'h0);

        rst = 1'b1;
        #1;
        sample(0);
        for (int k = 1; k < 160; k++) begin
            @(negedge clk);
            sample(k);
        end

        check_eq("fetch_c0", trace[0], 64'h0);
        check_eq("fetch_c1", trace[1], 64'h4);
        check_eq("fetch_c2", trace[2], 64'h8);
        check_eq("beq_redirect", trace[7], 64'h1C);
        check_eq("jal_redirect", trace[11], 64'h28);
        check_eq("fwd_no_stall", 64'(visits[8'h0C >> 2]), 64'd1);
        check_eq("target_fetch_once", 64'(visits[8'h1C >> 2]), 64'd1);
        check_eq("lw_add_fetch", 64'(visits[8'h74 >> 2]), 64'd1);
        check_eq("load_use_bubble", 64'(visits[8'h78 >> 2]), 64'd2);
        check_eq("lw_ctrl_cycles", 64'(n_lw), 64'd1);
        check_eq("store_count", 64'(n_st), 64'd16);
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("st%0d_addr", k), st_addr[k], exp_addr[k]);
            check_eq($sformatf("st%0d_data", k), st_data[k], exp_data[k]);
            check_eq($sformatf("st%0d_ctrl", k), {61'd0, st_ctrl[k]}, {61'd0, exp_ctrl[k]});
        end
        check_eq("mem_byte8", {56'd0, dmem[8]}, 64'h88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
